capture_ctrl: RTL and testbench

Capture sequencer for the DSO acquisition path. It sits directly downstream of the trigger block. It decimates the sample stream, writes samples into the circular capture RAM, and raises `armed` once enough pre-trigger history is stored. After `triggered` arrives, it counts the post-trigger samples, then pulses `set_capture_done` back to the trigger block and freezes the trace.

---
 rtl/dso_pkg.sv | 17 +
 rtl/smpl_strobe.sv | 37 +++
 rtl/capture_ctrl.sv | 158 +++++++++++++++
 tb/tb_capture_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
// Shared types and constants for the DSO acquisition path.
//   capture_state_t : capture sequencer states
//   DEF_ENTRIES     : default capture RAM depth in samples
//   DEC_PWR_W       : width of the decimation exponent
package dso_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      ARMED,
      DONE
   } capture_state_t;

   localparam int DEF_ENTRIES = 384;
   localparam int DEC_PWR_W   = 4;

endpackage

// File: rtl/smpl_strobe.sv
// Decimated sample strobe.
// Counts clocks while run is high and fires strobe when the count reaches
// 2^dec_pwr-1, then wraps. The count is held at 0 while run is low, so every
// run period starts fresh.
//   clk, rst : clock, synchronous active-high reset
//   run      : count enable
//   dec_pwr  : decimation exponent (one strobe every 2^dec_pwr clocks)
//   strobe   : decimated write strobe
module smpl_strobe
   import dso_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [DEC_PWR_W-1:0] dec_pwr,
   output logic                 strobe
);

   // Largest terminal count is 2^(2^DEC_PWR_W - 1) - 1.
   localparam int CNT_W = (1 << DEC_PWR_W) - 1;

   logic [CNT_W-1:0] cnt_q, cnt_d, limit;

   always_comb begin
      limit  = CNT_W'((32'd1 << dec_pwr) - 32'd1);
      strobe = run && (cnt_q == limit);
      cnt_d  = cnt_q;
      if (!run || strobe) cnt_d = '0;
      else                cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: decimates the sample stream, writes the circular capture
// RAM, arms the trigger once pre-trigger history is complete, counts
// post-trigger samples and freezes the trace.
//   clk, rst          : clock, synchronous active-high reset
//   capture_en        : run request (level)
//   dec_pwr           : decimation exponent, latched on FILL entry
//   trig_pos          : post-trigger sample count, clamped and latched on FILL entry
//   clr_capture_done  : host acknowledge
//   triggered         : sticky trigger status
//   armed             : pre-trigger history complete
//   set_capture_done  : one-cycle pulse that clears triggered
//   we, waddr         : capture RAM write strobe/address
//   trace_end         : address of the last sample of the completed capture
//   capture_done      : sticky capture-complete status
module capture_ctrl
   import dso_pkg::*;
#(
   parameter int ENTRIES = DEF_ENTRIES,
   parameter int ADDR_W  = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 capture_en,
   input  logic [DEC_PWR_W-1:0] dec_pwr,
   input  logic [ADDR_W-1:0]    trig_pos,
   input  logic                 clr_capture_done,
   input  logic                 triggered,
   output logic                 armed,
   output logic                 set_capture_done,
   output logic                 we,
   output logic [ADDR_W-1:0]    waddr,
   output logic [ADDR_W-1:0]    trace_end,
   output logic                 capture_done
);

   // One extra bit so the write count can hold ENTRIES itself.
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  ENT      = CNT_W'(ENTRIES);
   localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(ENTRIES - 1);

   capture_state_t       state_q, state_d;
   logic [ADDR_W-1:0]    waddr_q, waddr_d;
   logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0]    post_cnt_q, post_cnt_d;
   logic [ADDR_W-1:0]    tp_q, tp_d;
   logic [DEC_PWR_W-1:0] dec_q, dec_d;
   logic [ADDR_W-1:0]    trace_end_q, trace_end_d;
   logic                 capture_done_q, capture_done_d;
   logic                 set_done_q, set_done_d;
   logic                 armed_q, armed_d;
   logic                 run, strobe, we_int;

   assign run = (state_q == FILL) || (state_q == ARMED);

   smpl_strobe u_strobe (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .dec_pwr (dec_q),
      .strobe  (strobe)
   );

   // No write in an abort or reset cycle: that sample would be discarded anyway.
   assign we_int = strobe && capture_en && !rst;

   always_comb begin
      state_d        = state_q;
      waddr_d        = waddr_q;
      wr_cnt_d       = wr_cnt_q;
      post_cnt_d     = post_cnt_q;
      tp_d           = tp_q;
      dec_d          = dec_q;
      trace_end_d    = trace_end_q;
      capture_done_d = capture_done_q;
      set_done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (capture_en && !capture_done_q) begin
               state_d = FILL;
               dec_d   = dec_pwr;
               if (trig_pos == '0)                tp_d = ADDR_W'(1);
               else if ({1'b0, trig_pos} >= ENT)  tp_d = LAST_ADR;
               else                               tp_d = trig_pos;
            end
         end
         FILL, ARMED: begin
            if (!capture_en) begin
               state_d = IDLE;
            end else if (we_int) begin
               waddr_d  = (waddr_q == LAST_ADR) ? '0 : waddr_q + 1'b1;
               wr_cnt_d = (wr_cnt_q == ENT) ? ENT : wr_cnt_q + 1'b1;
               if (state_q == FILL) begin
                  if (wr_cnt_d == ENT - {1'b0, tp_q}) state_d = ARMED;
               end else if (triggered) begin
                  post_cnt_d = post_cnt_q + 1'b1;
                  if (post_cnt_d == tp_q) begin
                     state_d        = DONE;
                     trace_end_d    = waddr_q;
                     capture_done_d = 1'b1;
                     set_done_d     = 1'b1;
                  end
               end
            end
         end
         DONE: begin
            if (clr_capture_done) begin
               state_d        = IDLE;
               capture_done_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Every way into IDLE starts the next capture from a clean slate.
      if (state_d == IDLE) begin
         waddr_d    = '0;
         wr_cnt_d   = '0;
         post_cnt_d = '0;
      end

      armed_d = (state_d == ARMED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         waddr_q        <= '0;
         wr_cnt_q       <= '0;
         post_cnt_q     <= '0;
         tp_q           <= ADDR_W'(1);
         dec_q          <= '0;
         trace_end_q    <= '0;
         capture_done_q <= 1'b0;
         set_done_q     <= 1'b0;
         armed_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         waddr_q        <= waddr_d;
         wr_cnt_q       <= wr_cnt_d;
         post_cnt_q     <= post_cnt_d;
         tp_q           <= tp_d;
         dec_q          <= dec_d;
         trace_end_q    <= trace_end_d;
         capture_done_q <= capture_done_d;
         set_done_q     <= set_done_d;
         armed_q        <= armed_d;
      end
   end

   assign armed            = armed_q;
   assign set_capture_done = set_done_q;
   assign we               = we_int;
   assign waddr            = waddr_q;
   assign trace_end        = trace_end_q;
   assign capture_done     = capture_done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl with ENTRIES=8. ADDR_W=4 so that a
// trig_pos of 9 can actually be driven onto the port.
// Stimulus pushes the expected write (cycle, address, armed) and done-pulse
// (cycle, trace_end) records; a negedge monitor pops and compares them.
module tb_capture_ctrl;

   localparam int E  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          capture_en;
   logic [3:0]    dec_pwr;
   logic [AW-1:0] trig_pos;
   logic          clr_capture_done;
   logic          triggered;
   logic          armed, set_capture_done, we, capture_done;
   logic [AW-1:0] waddr, trace_end;

   capture_ctrl #(.ENTRIES(E), .ADDR_W(AW)) dut (
      .clk              (clk),
      .rst              (rst),
      .capture_en       (capture_en),
      .dec_pwr          (dec_pwr),
      .trig_pos         (trig_pos),
      .clr_capture_done (clr_capture_done),
      .triggered        (triggered),
      .armed            (armed),
      .set_capture_done (set_capture_done),
      .we               (we),
      .waddr            (waddr),
      .trace_end        (trace_end),
      .capture_done     (capture_done)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; int addr; int armed; } wr_t;
   typedef struct { int cyc; int tend; } dn_t;

   wr_t wq[$];
   dn_t dq[$];
   wr_t me;
   dn_t md;
   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  last_tend = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every write and every done pulse must match a queued expectation.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (wq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_we: got waddr %0d, expected no write (cycle %0d)", waddr, cyc);
         end else begin
            me = wq.pop_front();
            chk("we_cycle", cyc, me.cyc);
            chk("waddr", int'(waddr), me.addr);
            chk("armed_at_write", int'(armed), me.armed);
         end
      end
      if (set_capture_done === 1'b1) begin
         if (dq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done_pulse: got pulse, expected none (cycle %0d)", cyc);
         end else begin
            md = dq.pop_front();
            chk("done_cycle", cyc, md.cyc);
            chk("trace_end", int'(trace_end), md.tend);
            chk("capture_done_at_pulse", int'(capture_done), 1);
            chk("armed_at_done", int'(armed), 0);
         end
      end
   end

   function automatic int eff_tp(input int tpos);
      if (tpos == 0) return 1;
      if (tpos >= E) return E - 1;
      return tpos;
   endfunction

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start(input int p, input int tpos, output int t0);
      dec_pwr    = 4'(p);
      trig_pos   = AW'(tpos);
      capture_en = 1'b1;
      t0         = cyc + 1;
   endtask

   // Full capture whose first FILL cycle is t0; triggered rises after n writes.
   task automatic do_capture(input int p, input int tpos, input int n, input int t0);
      int tp, per, tf;
      tp  = eff_tp(tpos);
      per = 1 << p;
      for (int k = 0; k < n + tp; k++)
         wq.push_back(wr_t'{t0 + (k + 1) * per - 1, k % E, (k >= E - tp) ? 1 : 0});
      tf = t0 + (n + tp) * per - 1;
      last_tend = (n + tp - 1) % E;
      dq.push_back(dn_t'{tf + 1, last_tend});
      wait_cyc(t0);
      dec_pwr  = 4'($urandom);
      trig_pos = AW'($urandom);
      wait_cyc(t0 + n * per);
      triggered = 1'b1;
      wait_cyc(tf + 2);
      triggered = 1'b0;
      chk("capture_done_held", int'(capture_done), 1);
      chk("we_after_done", int'(we), 0);
   endtask

   task automatic finish_ack();
      capture_en       = 1'b0;
      clr_capture_done = 1'b1;
      @(posedge clk); #1;
      clr_capture_done = 1'b0;
      chk("ack_capture_done", int'(capture_done), 0);
      chk("ack_waddr", int'(waddr), 0);
   endtask

   initial begin
      int t0, c, p, tpos, n;
      rst = 1'b1; capture_en = 1'b0; dec_pwr = '0; trig_pos = '0;
      clr_capture_done = 1'b0; triggered = 1'b0;
      @(posedge clk); #1;
      chk("rst_armed", int'(armed), 0);
      chk("rst_set_done", int'(set_capture_done), 0);
      chk("rst_we", int'(we), 0);
      chk("rst_waddr", int'(waddr), 0);
      chk("rst_trace_end", int'(trace_end), 0);
      chk("rst_capture_done", int'(capture_done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_cyc(cyc + 2);

      // Basic capture: trace_end 3 after 9 pre writes and 3 post writes.
      start(0, 3, t0); do_capture(0, 3, 9, t0); finish_ack();
      // Decimation by 4 with address wrap.
      start(2, 5, t0); do_capture(2, 5, 8, t0); finish_ack();
      // Clamping low and high.
      start(0, 0, t0); do_capture(0, 0, 7, t0); finish_ack();
      start(1, 9, t0); do_capture(1, 9, 1, t0); finish_ack();

      // Abort while armed: writes stop, no done pulse, trace_end kept.
      start(0, 4, t0);
      for (int k = 0; k < 6; k++)
         wq.push_back(wr_t'{t0 + k, k, (k >= 4) ? 1 : 0});
      wait_cyc(t0 + 6);
      capture_en = 1'b0;
      @(posedge clk); #1;
      chk("abort_waddr", int'(waddr), 0);
      chk("abort_armed", int'(armed), 0);
      chk("abort_capture_done", int'(capture_done), 0);
      chk("abort_trace_end", int'(trace_end), last_tend);
      wait_cyc(cyc + 4);

      // Ack with capture_en held: one IDLE cycle, then a fresh capture.
      start(0, 2, t0); do_capture(0, 2, 6, t0);
      dec_pwr = 4'd1; trig_pos = AW'(6);
      clr_capture_done = 1'b1;
      c = cyc;
      @(posedge clk); #1;
      clr_capture_done = 1'b0;
      chk("rearm_capture_done", int'(capture_done), 0);
      chk("rearm_idle_waddr", int'(waddr), 0);
      chk("rearm_idle_we", int'(we), 0);
      do_capture(1, 6, 2, c + 2);
      finish_ack();

      // Reset mid-capture, landing on a would-be write cycle.
      start(1, 3, t0);
      for (int k = 0; k < 3; k++)
         wq.push_back(wr_t'{t0 + 2 * k + 1, k, 0});
      wait_cyc(t0 + 7);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      capture_en = 1'b0;
      chk("midrst_armed", int'(armed), 0);
      chk("midrst_waddr", int'(waddr), 0);
      chk("midrst_trace_end", int'(trace_end), 0);
      chk("midrst_capture_done", int'(capture_done), 0);
      chk("midrst_set_done", int'(set_capture_done), 0);
      wait_cyc(cyc + 4);

      // Randomized captures.
      for (int i = 0; i < 8; i++) begin
         p    = int'($urandom_range(0, 3));
         tpos = int'($urandom_range(0, 15));
         n    = E - eff_tp(tpos) + int'($urandom_range(0, 10));
         start(p, tpos, t0);
         do_capture(p, tpos, n, t0);
         finish_ack();
      end

      wait_cyc(cyc + 5);
      chk("writes_outstanding", wq.size(), 0);
      chk("done_outstanding", dq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
